ro_mmio_regfile: RTL and testbench
==================================

# ro_mmio_regfile

Parametrised MMIO register file for the ring-oscillator capture AFU. It is the host-facing control block for the DMA/capture pipeline. It holds the DMA read and write addresses, the sample count, the collect-cycle window and a per-oscillator channel-enable mask. It issues a guarded one-cycle `go` and an `abort`, and reports sticky done, busy, error and progress status. Unlike the previous single-channel map, it tracks run state and rejects illegal host writes.

## Interface
Parameters:
- ADDR_WIDTH, 64, DMA byte-address width.
- SIZE_WIDTH, 32, width of num_samples, collect_cycles and progress count.
- NUM_CH, 4, number of RO channels (1..32).
- BASE_ADDR, 16'h0050, MMIO word address of register 0.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- mmio  mmio_if.user  —  wr_en/wr_addr/wr_data and rd_en/rd_addr/rd_data (64-bit data, 16-bit word address).
- rd_addr, wr_addr  out  ADDR_WIDTH  DMA start addresses.
- num_samples  out  SIZE_WIDTH  cache lines to transfer.
- collect_cycles  out  SIZE_WIDTH  capture window per sample.
- ch_en  out  NUM_CH  channel-enable mask.
- go  out  1  one-cycle start pulse.
- abort  out  1  one-cycle abort pulse.
- done  in  1  level from datapath; high when the run is complete.
- progress  in  SIZE_WIDTH  samples written in the current run.

## Operation
- Register map. Offsets are in words from BASE_ADDR. Unused upper bits read 0.
  - +0x00 CTRL, write-only. bit0 GO, bit1 CLR (clears done_sticky and err), bit2 ABORT.
  - +0x02 RD_ADDR, +0x04 WR_ADDR, +0x06 NUM_SAMPLES, +0x08 COLLECT_CYCLES, +0x0A CH_EN. All are read/write.
  - +0x0C STATUS, read-only. bit0 done_sticky, bit1 busy, bit2 err, bits[15:8] NUM_CH.
  - +0x0E PROGRESS, read-only. Returns the `progress` input.
  - +0x10 VERSION, read-only. Returns the package constant.
- GO is accepted only when busy=0, num_samples≠0 and ch_en≠0. On acceptance: `go` pulses, busy←1, done_sticky←0. Otherwise: no pulse, err←1.
- Rising edge of `done`, detected against a registered copy of `done`, while busy=1: busy←0, done_sticky←1. A `done` edge while idle is ignored.
- ABORT while busy: `abort` pulses, busy←0, done_sticky unchanged. ABORT while idle is a no-op.
- A write to any config register while busy is dropped and sets err←1.
- Writes to read-only or unmapped addresses are ignored with no error.
- CLR and GO set in the same write: CLR is applied first, then the GO check.
- A single CTRL write with GO=1 and ABORT=1 is treated as ABORT only; err is not set.
- A `done` rising edge in the same cycle as an accepted GO cannot occur, because GO requires busy=0 and a `done` edge is only acted on while busy=1.

## Timing
- Reset values are all 0: every register, `go`, `abort`, busy, err, done_sticky, the done edge register and `mmio.rd_data`.
- Write path:
  - Config registers update on the clock edge after `wr_en`.
  - `go` and `abort` are high exactly one cycle: the cycle after the CTRL write.
  - busy rises in the same cycle `go` is high.
- Done path: `done` is registered once, then edge-detected. done_sticky and busy update 2 cycles after `done` rises.
- Read path:
  - `rd_data` is valid 1 cycle after `rd_en`.
  - `rd_data` holds its value when `rd_en`=0.
  - Unmapped addresses read 0.
  - A read and a write to the same register in the same cycle return the old value.
- Reset asserted mid-run clears busy and the config registers immediately, with no abort pulse. The datapath shares `rst`.

## Structure
- Package `ro_mmio_pkg` holds:
  - register offset localparams;
  - STATUS bit indices;
  - CTRL bit indices;
  - VERSION constant (32'h0002_0000);
  - typedef `ctrl_t` (packed struct go/clr/abort).
- Sub-module `rising_edge_detect`, clk/rst/in → pulse, instantiated for `done`.
- Everything else stays flat in one module: write always_ff, read always_ff, run-state logic.

## Test plan
- Reset, write RD_ADDR=64'h1000, NUM_SAMPLES=8, CH_EN=4'hF, read each back → same values, 1-cycle read latency; STATUS=0x0400.
- Write CTRL=1 → `go` high exactly 1 cycle; STATUS.busy=1. Raise `done` → 2 cycles later STATUS=0x0401.
- With NUM_SAMPLES=0, write CTRL=1 → no `go`; STATUS.err=1. Write CTRL=2 → err=0.
- While busy, write NUM_SAMPLES=99 → reads back old value 8; err=1. GO while busy → no pulse.
- While busy, write CTRL=4 → `abort` pulses 1 cycle, busy=0, done_sticky=0. Then a stray `done` edge → done_sticky stays 0.
- Assert `rst` mid-run → all outputs 0 next cycle. Read of 16'h00F0 → 0.

Source files
------------

// File: rtl/ro_mmio_regfile_pkg.sv
// Shared constants and types for the ring-oscillator capture MMIO register file.
package ro_mmio_pkg;

  // Host bus geometry: word-addressed, 64-bit data.
  localparam int MMIO_AW = 16;
  localparam int MMIO_DW = 64;

  // Register offsets, in words from the block's base address.
  localparam logic [15:0] OFF_CTRL           = 16'h0000;
  localparam logic [15:0] OFF_RD_ADDR        = 16'h0002;
  localparam logic [15:0] OFF_WR_ADDR        = 16'h0004;
  localparam logic [15:0] OFF_NUM_SAMPLES    = 16'h0006;
  localparam logic [15:0] OFF_COLLECT_CYCLES = 16'h0008;
  localparam logic [15:0] OFF_CH_EN          = 16'h000A;
  localparam logic [15:0] OFF_STATUS         = 16'h000C;
  localparam logic [15:0] OFF_PROGRESS       = 16'h000E;
  localparam logic [15:0] OFF_VERSION        = 16'h0010;

  // STATUS bit positions.
  localparam int STAT_DONE      = 0;
  localparam int STAT_BUSY      = 1;
  localparam int STAT_ERR       = 2;
  localparam int STAT_NUMCH_LSB = 8;

  // CTRL bit positions.
  localparam int CTRL_GO    = 0;
  localparam int CTRL_CLR   = 1;
  localparam int CTRL_ABORT = 2;

  localparam logic [31:0] VERSION = 32'h0002_0000;

  // Decoded CTRL write; go lands in bit 0.
  typedef struct packed {
    logic abort;
    logic clr;
    logic go;
  } ctrl_t;

endpackage

// File: rtl/ro_mmio_regfile_if.sv
// Host MMIO bus: independent write and read channels sharing one clock.
interface mmio_if;
  import ro_mmio_pkg::*;

  logic               wr_en;
  logic [MMIO_AW-1:0] wr_addr;
  logic [MMIO_DW-1:0] wr_data;
  logic               rd_en;
  logic [MMIO_AW-1:0] rd_addr;
  logic [MMIO_DW-1:0] rd_data;

  // Register-file side.
  modport user (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data
  );

  // Host side.
  modport host (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data
  );
endinterface

// File: rtl/ro_mmio_regfile_rising_edge_detect.sv
// Registers the input once and flags the cycle where the registered copy rises.
module rising_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);
  logic r_in_q;
  logic r_in_qq;

  // Two-stage history: r_in_q is the registered input, r_in_qq its previous value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_q  <= 1'b0;
      r_in_qq <= 1'b0;
    end else begin
      r_in_q  <= in;
      r_in_qq <= r_in_q;
    end
  end

  assign pulse = r_in_q & ~r_in_qq;
endmodule

// File: rtl/ro_mmio_regfile.sv
// Host-facing control/status registers for the RO capture DMA pipeline.
module ro_mmio_regfile
  import ro_mmio_pkg::*;
#(
  parameter int          ADDR_WIDTH = 64,
  parameter int          SIZE_WIDTH = 32,
  parameter int          NUM_CH     = 4,
  parameter logic [15:0] BASE_ADDR  = 16'h0050
) (
  input  logic                  clk,
  input  logic                  rst,
  mmio_if.user                  mmio,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [SIZE_WIDTH-1:0] num_samples,
  output logic [SIZE_WIDTH-1:0] collect_cycles,
  output logic [NUM_CH-1:0]     ch_en,
  output logic                  go,
  output logic                  abort,
  input  logic                  done,
  input  logic [SIZE_WIDTH-1:0] progress
);

  localparam logic [15:0] A_CTRL    = BASE_ADDR + OFF_CTRL;
  localparam logic [15:0] A_RD_ADDR = BASE_ADDR + OFF_RD_ADDR;
  localparam logic [15:0] A_WR_ADDR = BASE_ADDR + OFF_WR_ADDR;
  localparam logic [15:0] A_NUM     = BASE_ADDR + OFF_NUM_SAMPLES;
  localparam logic [15:0] A_COLLECT = BASE_ADDR + OFF_COLLECT_CYCLES;
  localparam logic [15:0] A_CH_EN   = BASE_ADDR + OFF_CH_EN;
  localparam logic [15:0] A_STATUS  = BASE_ADDR + OFF_STATUS;
  localparam logic [15:0] A_PROG    = BASE_ADDR + OFF_PROGRESS;
  localparam logic [15:0] A_VERSION = BASE_ADDR + OFF_VERSION;

  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [SIZE_WIDTH-1:0] r_num_samples;
  logic [SIZE_WIDTH-1:0] r_collect_cycles;
  logic [NUM_CH-1:0]     r_ch_en;
  logic                  r_go;
  logic                  r_abort;
  logic                  r_busy;
  logic                  r_err;
  logic                  r_done_sticky;
  logic [MMIO_DW-1:0]    r_rd_data;

  ctrl_t                 w_ctrl;
  logic                  w_ctrl_wr;
  logic                  w_cfg_wr;
  logic                  w_go_req;
  logic                  w_go_ok;
  logic                  w_go_rej;
  logic                  w_abort_ok;
  logic                  w_clr;
  logic                  w_done_rise;
  logic                  w_done_act;
  logic [MMIO_DW-1:0]    w_status;

  rising_edge_detect u_done_edge (
    .clk   (clk),
    .rst   (rst),
    .in    (done),
    .pulse (w_done_rise)
  );

  // Write decode and the GO/ABORT acceptance rules.
  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_ctrl       = '0;
    w_ctrl.go    = mmio.wr_data[CTRL_GO];
    w_ctrl.clr   = mmio.wr_data[CTRL_CLR];
    w_ctrl.abort = mmio.wr_data[CTRL_ABORT];
    w_ctrl_wr    = mmio.wr_en && (mmio.wr_addr == A_CTRL);
    w_cfg_wr     = mmio.wr_en && ((mmio.wr_addr == A_RD_ADDR) || (mmio.wr_addr == A_WR_ADDR) ||
                                  (mmio.wr_addr == A_NUM)     || (mmio.wr_addr == A_COLLECT) ||
                                  (mmio.wr_addr == A_CH_EN));
    // ABORT in the same write masks GO entirely.
    w_go_req     = w_ctrl_wr && w_ctrl.go && !w_ctrl.abort;
    w_go_ok      = w_go_req && !r_busy && (r_num_samples != '0) && (r_ch_en != '0);
    w_go_rej     = w_go_req && !w_go_ok;
    w_abort_ok   = w_ctrl_wr && w_ctrl.abort && r_busy;
    w_clr        = w_ctrl_wr && w_ctrl.clr;
    w_done_act   = w_done_rise && r_busy;
  end

  // Config registers: host writes land only while idle.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr        <= '0;
      r_wr_addr        <= '0;
      r_num_samples    <= '0;
      r_collect_cycles <= '0;
      r_ch_en          <= '0;
    end else if (mmio.wr_en && !r_busy) begin
      case (mmio.wr_addr)
        A_RD_ADDR: r_rd_addr        <= mmio.wr_data[ADDR_WIDTH-1:0];
        A_WR_ADDR: r_wr_addr        <= mmio.wr_data[ADDR_WIDTH-1:0];
        A_NUM:     r_num_samples    <= mmio.wr_data[SIZE_WIDTH-1:0];
        A_COLLECT: r_collect_cycles <= mmio.wr_data[SIZE_WIDTH-1:0];
        A_CH_EN:   r_ch_en          <= mmio.wr_data[NUM_CH-1:0];
        default:   ;
      endcase
    end
  end

  // Run state: go/abort pulses, busy, sticky done and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_go          <= 1'b0;
      r_abort       <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
      r_done_sticky <= 1'b0;
    end else begin
      r_go    <= w_go_ok;
      r_abort <= w_abort_ok;

      if (w_go_ok)                       r_busy <= 1'b1;
      else if (w_abort_ok || w_done_act) r_busy <= 1'b0;

      if (w_done_act)              r_done_sticky <= 1'b1;
      else if (w_go_ok || w_clr)   r_done_sticky <= 1'b0;

      // CLR acts first; a rejected GO in the same write still flags an error.
      if (w_go_rej || (w_cfg_wr && r_busy)) r_err <= 1'b1;
      else if (w_clr)                       r_err <= 1'b0;
    end
  end

  // STATUS word assembly.
  always_comb begin
    w_status                              = '0;
    w_status[STAT_DONE]                   = r_done_sticky;
    w_status[STAT_BUSY]                   = r_busy;
    w_status[STAT_ERR]                    = r_err;
    w_status[STAT_NUMCH_LSB +: 8]         = 8'(NUM_CH);
  end

  // Registered read port; holds its value when no read is requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (mmio.rd_en) begin
      case (mmio.rd_addr)
        A_RD_ADDR: r_rd_data <= 64'(r_rd_addr);
        A_WR_ADDR: r_rd_data <= 64'(r_wr_addr);
        A_NUM:     r_rd_data <= 64'(r_num_samples);
        A_COLLECT: r_rd_data <= 64'(r_collect_cycles);
        A_CH_EN:   r_rd_data <= 64'(r_ch_en);
        A_STATUS:  r_rd_data <= w_status;
        A_PROG:    r_rd_data <= 64'(progress);
        A_VERSION: r_rd_data <= 64'(VERSION);
        default:   r_rd_data <= '0;
      endcase
    end
  end

  assign mmio.rd_data   = r_rd_data;
  assign rd_addr        = r_rd_addr;
  assign wr_addr        = r_wr_addr;
  assign num_samples    = r_num_samples;
  assign collect_cycles = r_collect_cycles;
  assign ch_en          = r_ch_en;
  assign go             = r_go;
  assign abort          = r_abort;

endmodule

// File: tb/tb_ro_mmio_regfile.sv
// Directed bench for ro_mmio_regfile; reads are scored through an expected-value queue.
module tb_ro_mmio_regfile;

  localparam logic [15:0] A_CTRL    = 16'h0050;
  localparam logic [15:0] A_RD_ADDR = 16'h0052;
  localparam logic [15:0] A_WR_ADDR = 16'h0054;
  localparam logic [15:0] A_NUM     = 16'h0056;
  localparam logic [15:0] A_COLLECT = 16'h0058;
  localparam logic [15:0] A_CH_EN   = 16'h005A;
  localparam logic [15:0] A_STATUS  = 16'h005C;
  localparam logic [15:0] A_PROG    = 16'h005E;
  localparam logic [15:0] A_VERSION = 16'h0060;
  localparam logic [15:0] A_UNMAP   = 16'h00F0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done = 1'b0;
  logic [31:0] progress = '0;
  logic [63:0] dma_rd_addr;
  logic [63:0] dma_wr_addr;
  logic [31:0] num_samples;
  logic [31:0] collect_cycles;
  logic [3:0]  ch_en;
  logic        go;
  logic        abort;

  int   checks   = 0;
  int   failures = 0;
  sb_t  sb[$];
  sb_t  sb_head;
  logic rd_pend = 1'b0;

  mmio_if u_if ();

  ro_mmio_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .mmio           (u_if),
    .rd_addr        (dma_rd_addr),
    .wr_addr        (dma_wr_addr),
    .num_samples    (num_samples),
    .collect_cycles (collect_cycles),
    .ch_en          (ch_en),
    .go             (go),
    .abort          (abort),
    .done           (done),
    .progress       (progress)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    u_if.wr_en   = 1'b1;
    u_if.wr_addr = a;
    u_if.wr_data = d;
    tick();
    u_if.wr_en   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [63:0] e);
    sb_t item;
    item.tag     = tag;
    item.exp     = e;
    sb.push_back(item);
    u_if.rd_en   = 1'b1;
    u_if.rd_addr = a;
    tick();
    u_if.rd_en   = 1'b0;
  endtask

  // Read data is due one edge after the request; compare it mid-cycle.
  always @(posedge clk) rd_pend <= u_if.rd_en;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        sb_head = sb.pop_front();
        check(sb_head.tag, u_if.rd_data, sb_head.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    u_if.wr_en   = 1'b0;
    u_if.wr_addr = '0;
    u_if.wr_data = '0;
    u_if.rd_en   = 1'b0;
    u_if.rd_addr = '0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    check("rst_go", 64'(go), 64'd0);
    check("rst_abort", 64'(abort), 64'd0);
    check("rst_rd_addr", dma_rd_addr, 64'd0);
    check("rst_num", 64'(num_samples), 64'd0);
    check("rst_ch_en", 64'(ch_en), 64'd0);
    check("rst_rd_data", u_if.rd_data, 64'd0);

    // Configuration write and read-back; upper CH_EN bits are dropped.
    wr(A_RD_ADDR, 64'h1000);
    wr(A_WR_ADDR, 64'h2000);
    wr(A_NUM, 64'd8);
    wr(A_COLLECT, 64'd100);
    wr(A_CH_EN, 64'hFFFF_0000_0000_00FF);
    check("port_rd_addr", dma_rd_addr, 64'h1000);
    check("port_ch_en", 64'(ch_en), 64'hF);
    progress = 32'h1234;
    rd("rb_rd_addr", A_RD_ADDR, 64'h1000);
    rd("rb_wr_addr", A_WR_ADDR, 64'h2000);
    rd("rb_num", A_NUM, 64'd8);
    rd("rb_collect", A_COLLECT, 64'd100);
    rd("rb_ch_en", A_CH_EN, 64'hF);
    rd("status_idle", A_STATUS, 64'h0400);
    rd("progress", A_PROG, 64'h1234);
    rd("ctrl_reads_0", A_CTRL, 64'h0);
    rd("version", A_VERSION, 64'h0002_0000);
    tick();
    tick();
    check("rd_hold", u_if.rd_data, 64'h0002_0000);

    // Accepted GO, then completion two edges after done rises.
    wr(A_CTRL, 64'h1);
    check("go_pulse", 64'(go), 64'd1);
    tick();
    check("go_one_cycle", 64'(go), 64'd0);
    rd("status_busy", A_STATUS, 64'h0402);
    done = 1'b1;
    tick();
    rd("status_done_1cyc", A_STATUS, 64'h0402);
    rd("status_done_2cyc", A_STATUS, 64'h0401);
    done = 1'b0;
    tick();

    // GO rejected for zero samples; CLR clears err and done_sticky.
    wr(A_NUM, 64'd0);
    wr(A_CTRL, 64'h1);
    check("go_rej_zero", 64'(go), 64'd0);
    rd("status_err", A_STATUS, 64'h0405);
    wr(A_CTRL, 64'h2);
    rd("status_clr", A_STATUS, 64'h0400);
    wr(A_NUM, 64'd8);

    // Config write and GO while busy are dropped and flag err.
    wr(A_CTRL, 64'h1);
    check("go_pulse2", 64'(go), 64'd1);
    wr(A_NUM, 64'd99);
    rd("num_locked", A_NUM, 64'd8);
    rd("status_busy_err", A_STATUS, 64'h0406);
    wr(A_CTRL, 64'h1);
    check("go_while_busy", 64'(go), 64'd0);

    // ABORT while busy; a later stray done edge is ignored.
    wr(A_CTRL, 64'h4);
    check("abort_pulse", 64'(abort), 64'd1);
    tick();
    check("abort_one_cycle", 64'(abort), 64'd0);
    rd("status_aborted", A_STATUS, 64'h0404);
    done = 1'b1;
    tick();
    tick();
    tick();
    done = 1'b0;
    tick();
    rd("status_stray_done", A_STATUS, 64'h0404);

    // CLR+GO together clears err then starts; GO+ABORT is abort only.
    wr(A_CTRL, 64'h3);
    check("clr_go_pulse", 64'(go), 64'd1);
    rd("status_clr_go", A_STATUS, 64'h0402);
    wr(A_CTRL, 64'h5);
    check("go_abort_abort", 64'(abort), 64'd1);
    check("go_abort_no_go", 64'(go), 64'd0);
    rd("status_go_abort", A_STATUS, 64'h0400);

    // Read-only and unmapped writes are silent.
    wr(A_STATUS, 64'hFFFF);
    wr(A_UNMAP, 64'hFFFF);
    rd("status_ro_write", A_STATUS, 64'h0400);

    // Simultaneous read and write of one register returns the old value.
    u_if.wr_en   = 1'b1;
    u_if.wr_addr = A_COLLECT;
    u_if.wr_data = 64'd200;
    rd("rw_same_old", A_COLLECT, 64'd100);
    u_if.wr_en   = 1'b0;
    rd("rw_same_new", A_COLLECT, 64'd200);

    // Reset mid-run clears everything at the next edge, with no abort.
    wr(A_CTRL, 64'h1);
    check("go_pulse3", 64'(go), 64'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_go", 64'(go), 64'd0);
    check("mid_rst_abort", 64'(abort), 64'd0);
    check("mid_rst_rd_addr", dma_rd_addr, 64'd0);
    check("mid_rst_wr_addr", dma_wr_addr, 64'd0);
    check("mid_rst_num", 64'(num_samples), 64'd0);
    check("mid_rst_collect", 64'(collect_cycles), 64'd0);
    check("mid_rst_ch_en", 64'(ch_en), 64'd0);
    check("mid_rst_rd_data", u_if.rd_data, 64'd0);
    rst = 1'b0;
    rd("status_after_rst", A_STATUS, 64'h0400);
    rd("unmapped", A_UNMAP, 64'h0);
    tick();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
